// File: rtl/gen_tree_zero_finder.sv
// Zero-bit locator: snapshots a WIDTH-bit vector and walks its CHUNK-ary AND tree top-down,
// one level per clock. Define GEN_TREE_SEARCH_HIGH_EN to locate the highest-index zero instead of the lowest.
module gen_tree_zero_finder #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         input_bits,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic                     all_ones,
  output logic [$clog2(WIDTH)-1:0] index
);

  localparam int IDX_W  = $clog2(WIDTH);
  localparam int CW     = $clog2(CHUNK);
  localparam int LEVELS = IDX_W / CW;
  localparam int LW     = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  if ((CHUNK < 2) || ((1 << CW) != CHUNK)) begin : g_bad_chunk
    $error("gen_tree_zero_finder: CHUNK must be a power of 2 and at least 2");
  end
  if (WIDTH != (1 << (LEVELS * CW))) begin : g_bad_width
    $error("gen_tree_zero_finder: WIDTH must be a power of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WALK  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   snapshot_q, snapshot_d;
  logic [IDX_W-1:0]   prefix_q, prefix_d;
  logic [LW-1:0]      level_q, level_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               found_q, found_d;
  logic               all_ones_q, all_ones_d;
  logic [IDX_W-1:0]   index_q, index_d;

  // Levels 0..LEVELS-1 of the AND tree; the root is reduced separately from the top stored level.
  logic [LEVELS-1:0][WIDTH-1:0] tree_s;
  logic                         root_s;
  logic [WIDTH-1:0]             level_vec_s;
  logic [IDX_W-1:0]             shift_s;
  logic [CHUNK-1:0]             children_s;
  logic [CW-1:0]                pick_s;
  logic [IDX_W-1:0]             new_prefix_s;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    logic [WIDTH-1:0] val_s;
    if (l == 0) begin : g_leaf
      assign val_s = snapshot_q;
    end else begin : g_node
      // Chunk-AND of the level below; positions past this level's population stay 0.
      always_comb begin
        val_s = '0;
        for (int q = 0; q < WIDTH / CHUNK; q++) begin
          val_s[q] = &g_lvl[l-1].val_s[q*CHUNK +: CHUNK];
        end
      end
    end
    assign tree_s[l] = val_s;
  end

  assign root_s       = &tree_s[LEVELS-1][CHUNK-1:0];
  assign level_vec_s  = tree_s[level_q];
  assign shift_s      = prefix_q << CW;
  assign children_s   = CHUNK'(level_vec_s >> shift_s);
  assign new_prefix_s = (prefix_q << CW) | IDX_W'(pick_s);

  // Child selection: the last assignment in loop order wins, so loop direction sets the priority.
  always_comb begin
    pick_s = '0;
`ifdef GEN_TREE_SEARCH_HIGH_EN
    for (int j = 0; j < CHUNK; j++) begin
      pick_s = children_s[j] ? pick_s : CW'(j);
    end
`else
    for (int j = CHUNK - 1; j >= 0; j--) begin
      pick_s = children_s[j] ? pick_s : CW'(j);
    end
`endif
  end

  // Next-state and next-output computation for the search FSM.
  always_comb begin
    state_d    = state_q;
    snapshot_d = snapshot_q;
    prefix_d   = prefix_q;
    level_d    = level_q;
    found_d    = found_q;
    all_ones_d = all_ones_q;
    index_d    = index_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CHECK;
          snapshot_d = input_bits;
          found_d    = 1'b0;
          all_ones_d = 1'b0;
          index_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (root_s) begin
          state_d    = ST_DONE;
          all_ones_d = 1'b1;
          found_d    = 1'b0;
          index_d    = '0;
        end else begin
          state_d  = ST_WALK;
          level_d  = LW'(LEVELS - 1);
          prefix_d = '0;
        end
      end
      ST_WALK: begin
        prefix_d = new_prefix_s;
        if (level_q == '0) begin
          index_d = new_prefix_s;
          found_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          level_d = level_q - LW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_CHECK) || (state_d == ST_WALK);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      snapshot_q <= '0;
      prefix_q   <= '0;
      level_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      all_ones_q <= 1'b0;
      index_q    <= '0;
    end else begin
      state_q    <= state_d;
      snapshot_q <= snapshot_d;
      prefix_q   <= prefix_d;
      level_q    <= level_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      found_q    <= found_d;
      all_ones_q <= all_ones_d;
      index_q    <= index_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign found    = found_q;
  assign all_ones = all_ones_q;
  assign index    = index_q;

endmodule

// File: tb/tb_gen_tree_zero_finder.sv
// Directed bench for gen_tree_zero_finder at WIDTH=256, CHUNK=4; expectations follow GEN_TREE_SEARCH_HIGH_EN.
module tb_gen_tree_zero_finder;

  localparam int WIDTH = 256;
  localparam int CHUNK = 4;
  localparam int IDX_W = 8;
  localparam int LAT_ONES = 2;
  localparam int LAT_ZERO = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] input_bits;
  logic             busy, done, found, all_ones;
  logic [IDX_W-1:0] index;

  int n_vec = 0;
  int n_bad = 0;

  gen_tree_zero_finder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .input_bits (input_bits),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .all_ones   (all_ones),
    .index      (index)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] bits;
    logic             exp_all_ones;
    logic             exp_found;
    logic [IDX_W-1:0] exp_index;
    int               exp_lat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] clr2(input int a, input int b);
    logic [WIDTH-1:0] v;
    v = '1;
    if (a >= 0) v[a] = 1'b0;
    if (b >= 0) v[b] = 1'b0;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_bits();
    logic [WIDTH-1:0] v;
    for (int k = 0; k < WIDTH / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic vec_t mk(input string n, input logic [WIDTH-1:0] b, input logic ao,
                              input logic f, input int lo_idx, input int hi_idx, input int lat);
    vec_t v;
    v.name = n;
    v.bits = b;
    v.exp_all_ones = ao;
    v.exp_found = f;
`ifdef GEN_TREE_SEARCH_HIGH_EN
    v.exp_index = IDX_W'(hi_idx);
`else
    v.exp_index = IDX_W'(lo_idx);
`endif
    v.exp_lat = lat;
    return v;
  endfunction

  task automatic run_search(input vec_t v);
    int lat;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    input_bits = v.bits;
    @(posedge clk);
    #1;
    start = 1'b0;
    input_bits = rnd_bits();
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) check({v.name, "_busy_t1"}, 32'(busy), 32'(1));
      if (done) lat = c;
      input_bits = rnd_bits();
    end
    check({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, "_all_ones"}, 32'(all_ones), 32'(v.exp_all_ones));
    check({v.name, "_found"}, 32'(found), 32'(v.exp_found));
    check({v.name, "_index"}, 32'(index), 32'(v.exp_index));
    @(negedge clk);
    check({v.name, "_done_one_cycle"}, 32'(done), 32'(0));
    check({v.name, "_index_hold"}, 32'(index), 32'(v.exp_index));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int done_cyc;
    logic [IDX_W-1:0] done_idx;

    tbl[0] = mk("all_ones",   '1,            1'b1, 1'b0, 0,  0,   LAT_ONES);
    tbl[1] = mk("bit0",       clr2(0, -1),   1'b0, 1'b1, 0,  0,   LAT_ZERO);
    tbl[2] = mk("bits37_200", clr2(37, 200), 1'b0, 1'b1, 37, 200, LAT_ZERO);
    tbl[3] = mk("all_zero",   '0,            1'b0, 1'b1, 0,  255, LAT_ZERO);
    tbl[4] = mk("bit255",     clr2(255, -1), 1'b0, 1'b1, 255, 255, LAT_ZERO);
    tbl[5] = mk("bits1_2",    clr2(1, 2),    1'b0, 1'b1, 1,  2,   LAT_ZERO);
    tbl[6] = mk("bits3_64",   clr2(3, 64),   1'b0, 1'b1, 3,  64,  LAT_ZERO);
    tbl[7] = mk("bit100",     clr2(100, -1), 1'b0, 1'b1, 100, 100, LAT_ZERO);

    rst_n = 1'b0;
    start = 1'b0;
    input_bits = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_found", 32'(found), 32'(0));
    check("rst_all_ones", 32'(all_ones), 32'(0));
    check("rst_index", 32'(index), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_search(tbl[i]);

    // Start ignored while busy/done; input changes after the start edge are ignored.
    @(negedge clk);
    start = 1'b1;
    input_bits = clr2(255, -1);
    @(posedge clk);
    n_done = 0;
    done_cyc = -1;
    done_idx = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        done_cyc = c;
        done_idx = index;
      end
      if (c == 8) check("ignore_busy_after", 32'(busy), 32'(0));
      start = (c <= 6);
      input_bits = rnd_bits();
      input_bits[5] = 1'b0;
    end
    check("ignore_done_count", 32'(n_done), 32'(1));
    check("ignore_done_cycle", 32'(done_cyc), 32'(LAT_ZERO));
    check("ignore_index", 32'(done_idx), 32'(255));

    // Reset in the middle of a walk aborts with no done pulse.
    @(negedge clk);
    start = 1'b1;
    input_bits = clr2(100, -1);
    @(posedge clk);
    n_done = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (c == 4) begin
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_found", 32'(found), 32'(0));
        check("abort_index", 32'(index), 32'(0));
      end
      start = 1'b0;
      rst_n = (c != 3);
    end
    check("abort_no_done", 32'(n_done), 32'(0));
    run_search(mk("after_abort", clr2(100, -1), 1'b0, 1'b1, 100, 100, LAT_ZERO));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
